// File: rtl/gb80_pkg.sv
// Shared GB80 encodings: byte register codes, pair selects, pair ops and flag bit indices.
package gb80_pkg;

    typedef enum logic [2:0] {
        REG_B   = 3'd0,
        REG_C   = 3'd1,
        REG_D   = 3'd2,
        REG_E   = 3'd3,
        REG_H   = 3'd4,
        REG_L   = 3'd5,
        REG_MEM = 3'd6,
        REG_A   = 3'd7
    } reg_code_t;

    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_AF = 2'd3
    } pair_sel_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } pair_op_t;

    localparam int FLAG_Z     = 3;
    localparam int FLAG_N     = 2;
    localparam int FLAG_H     = 1;
    localparam int FLAG_C     = 0;
    localparam int FLAG_COUNT = 4;

    // AF has no byte-addressable low half; its low code is never used for writes.
    function automatic reg_code_t pair_hi_code(input int p);
        case (p)
            0:       return REG_B;
            1:       return REG_D;
            2:       return REG_H;
            default: return REG_A;
        endcase
    endfunction

    function automatic reg_code_t pair_lo_code(input int p);
        case (p)
            0:       return REG_C;
            1:       return REG_E;
            2:       return REG_L;
            default: return REG_MEM;
        endcase
    endfunction

endpackage

// File: rtl/gb_register_bank_if.sv
// Datapath-side bus of the GB80 register bank: byte write, dual read, pair access and flags.
interface gb_register_bank_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
);
    localparam int PAIR_WIDTH = 2 * DATA_WIDTH;

    logic                     i_wr_en;
    logic [ADDRESS_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0]    i_wr_data;
    logic                     i_rd_en;
    logic [ADDRESS_WIDTH-1:0] i_rd_addr_a;
    logic [ADDRESS_WIDTH-1:0] i_rd_addr_b;
    logic [DATA_WIDTH-1:0]    o_rd_data_a;
    logic [DATA_WIDTH-1:0]    o_rd_data_b;
    logic                     o_rd_valid;
    logic                     o_mem_sel;
    logic [1:0]               i_pair_sel;
    logic [1:0]               i_pair_op;
    logic [PAIR_WIDTH-1:0]    i_pair_data;
    logic [PAIR_WIDTH-1:0]    o_pair_data;
    logic [PAIR_WIDTH-1:0]    o_hl;
    logic [3:0]               i_flag_mask;
    logic [3:0]               i_flags;
    logic [3:0]               o_flags;

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data,
        input  i_rd_en, i_rd_addr_a, i_rd_addr_b,
        output o_rd_data_a, o_rd_data_b, o_rd_valid, o_mem_sel,
        input  i_pair_sel, i_pair_op, i_pair_data,
        output o_pair_data, o_hl,
        input  i_flag_mask, i_flags,
        output o_flags
    );

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data,
        output i_rd_en, i_rd_addr_a, i_rd_addr_b,
        input  o_rd_data_a, o_rd_data_b, o_rd_valid, o_mem_sel,
        output i_pair_sel, i_pair_op, i_pair_data,
        input  o_pair_data, o_hl,
        output i_flag_mask, i_flags,
        input  o_flags
    );

endinterface

// File: rtl/gb_reg_pair.sv
// One 16-bit register pair: byte writes, pair load/inc/dec, per-bit low-byte override and a
// constant low-byte keep mask. Exposes its next-state value so the bank can bypass reads.
module gb_reg_pair
    import gb80_pkg::*;
#(
    parameter int                        DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]     LO_MASK    = '1,
    parameter logic [2*DATA_WIDTH-1:0]   STEP       = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  pair_op_t                    i_op,
    input  logic [2*DATA_WIDTH-1:0]     i_load_data,
    input  logic                        i_hi_we,
    input  logic                        i_lo_we,
    input  logic [DATA_WIDTH-1:0]       i_byte_data,
    input  logic [DATA_WIDTH-1:0]       i_bit_mask,
    input  logic [DATA_WIDTH-1:0]       i_bit_data,
    output logic [DATA_WIDTH-1:0]       o_hi,
    output logic [DATA_WIDTH-1:0]       o_lo,
    output logic [DATA_WIDTH-1:0]       o_hi_next,
    output logic [DATA_WIDTH-1:0]       o_lo_next
);

    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [2*DATA_WIDTH-1:0] w_pair_next;
    logic [DATA_WIDTH-1:0]   w_lo_merged;

    // A pair op owns both bytes this cycle; byte writes only land when no op is active.
    always_comb begin
        w_pair_next = {r_hi, r_lo};
        case (i_op)
            OP_LOAD: w_pair_next = i_load_data;
            OP_INC:  w_pair_next = {r_hi, r_lo} + STEP;
            OP_DEC:  w_pair_next = {r_hi, r_lo} - STEP;
            default: begin
                if (i_hi_we) w_pair_next[2*DATA_WIDTH-1:DATA_WIDTH] = i_byte_data;
                if (i_lo_we) w_pair_next[DATA_WIDTH-1:0]            = i_byte_data;
            end
        endcase
        w_lo_merged = (w_pair_next[DATA_WIDTH-1:0] & ~i_bit_mask) | (i_bit_data & i_bit_mask);
    end

    assign o_hi_next = w_pair_next[2*DATA_WIDTH-1:DATA_WIDTH];
    assign o_lo_next = w_lo_merged & LO_MASK;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            r_hi <= o_hi_next;
            r_lo <= o_lo_next;
        end
    end

endmodule

// File: rtl/gb_register_bank.sv
// GB80 register bank: four register pairs behind byte-coded dual read ports with write bypass,
// pair access, masked flag update and a continuous HL address output.
module gb_register_bank
    import gb80_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    gb_register_bank_if.slave  bus
);

    localparam int PAIR_WIDTH = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] F_KEEP =
        ~(DATA_WIDTH'((1 << (DATA_WIDTH - FLAG_COUNT)) - 1));

    logic [3:0][DATA_WIDTH-1:0] w_hi_now;
    logic [3:0][DATA_WIDTH-1:0] w_lo_now;
    logic [3:0][DATA_WIDTH-1:0] w_hi_next;
    logic [3:0][DATA_WIDTH-1:0] w_lo_next;
    logic [7:0][DATA_WIDTH-1:0] w_code_val;
    logic [DATA_WIDTH-1:0]      w_flag_bitmask;
    logic [DATA_WIDTH-1:0]      w_flag_bits;

    logic [DATA_WIDTH-1:0]      r_rd_data_a;
    logic [DATA_WIDTH-1:0]      r_rd_data_b;
    logic                       r_rd_valid;
    logic                       r_mem_sel;

    assign w_flag_bitmask = DATA_WIDTH'(bus.i_flag_mask) << (DATA_WIDTH - FLAG_COUNT);
    assign w_flag_bits    = DATA_WIDTH'(bus.i_flags)     << (DATA_WIDTH - FLAG_COUNT);

    // F is not a counter, so AF inc/dec steps A alone and leaves the flag byte to the mask path.
    for (genvar p = 0; p < 4; p++) begin : g_pair
        localparam bit                      IS_AF   = (p == 3);
        localparam logic [DATA_WIDTH-1:0]   LMASK   = IS_AF ? F_KEEP : '1;
        localparam logic [PAIR_WIDTH-1:0]   PSTEP   = IS_AF ? (PAIR_WIDTH'(1) << DATA_WIDTH)
                                                            : PAIR_WIDTH'(1);
        localparam reg_code_t               HI_CODE = pair_hi_code(p);
        localparam reg_code_t               LO_CODE = pair_lo_code(p);

        pair_op_t               w_op;
        logic                   w_hi_we;
        logic                   w_lo_we;
        logic [DATA_WIDTH-1:0]  w_bit_mask;
        logic [DATA_WIDTH-1:0]  w_bit_data;

        assign w_op       = (bus.i_pair_sel == 2'(p)) ? pair_op_t'(bus.i_pair_op) : OP_NONE;
        assign w_hi_we    = bus.i_wr_en && (bus.i_wr_addr == HI_CODE);
        assign w_lo_we    = !IS_AF && bus.i_wr_en && (bus.i_wr_addr == LO_CODE);
        assign w_bit_mask = IS_AF ? w_flag_bitmask : '0;
        assign w_bit_data = IS_AF ? w_flag_bits : '0;

        gb_reg_pair #(
            .DATA_WIDTH (DATA_WIDTH),
            .LO_MASK    (LMASK),
            .STEP       (PSTEP)
        ) u_pair (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_op        (w_op),
            .i_load_data (bus.i_pair_data),
            .i_hi_we     (w_hi_we),
            .i_lo_we     (w_lo_we),
            .i_byte_data (bus.i_wr_data),
            .i_bit_mask  (w_bit_mask),
            .i_bit_data  (w_bit_data),
            .o_hi        (w_hi_now[p]),
            .o_lo        (w_lo_now[p]),
            .o_hi_next   (w_hi_next[p]),
            .o_lo_next   (w_lo_next[p])
        );
    end

    // Reads see next-state values so a same-cycle write or pair op is returned, not the old data.
    always_comb begin
        w_code_val          = '0;
        w_code_val[REG_B]   = w_hi_next[PAIR_BC];
        w_code_val[REG_C]   = w_lo_next[PAIR_BC];
        w_code_val[REG_D]   = w_hi_next[PAIR_DE];
        w_code_val[REG_E]   = w_lo_next[PAIR_DE];
        w_code_val[REG_H]   = w_hi_next[PAIR_HL];
        w_code_val[REG_L]   = w_lo_next[PAIR_HL];
        w_code_val[REG_MEM] = '0;
        w_code_val[REG_A]   = w_hi_next[PAIR_AF];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_valid  <= 1'b0;
            r_mem_sel   <= 1'b0;
        end else if (bus.i_rd_en) begin
            r_rd_data_a <= w_code_val[bus.i_rd_addr_a];
            r_rd_data_b <= w_code_val[bus.i_rd_addr_b];
            r_rd_valid  <= 1'b1;
            r_mem_sel   <= (bus.i_rd_addr_a == REG_MEM) || (bus.i_rd_addr_b == REG_MEM);
        end else begin
            r_rd_valid  <= 1'b0;
            r_mem_sel   <= 1'b0;
        end
    end

    assign bus.o_rd_data_a = r_rd_data_a;
    assign bus.o_rd_data_b = r_rd_data_b;
    assign bus.o_rd_valid  = r_rd_valid;
    assign bus.o_mem_sel   = r_mem_sel;
    assign bus.o_pair_data = {w_hi_now[bus.i_pair_sel], w_lo_now[bus.i_pair_sel]};
    assign bus.o_hl        = {w_hi_now[PAIR_HL], w_lo_now[PAIR_HL]};
    assign bus.o_flags     = w_lo_now[PAIR_AF][DATA_WIDTH-1 -: FLAG_COUNT];

endmodule

// File: tb/tb_gb_register_bank.sv
// Scoreboard bench for gb_register_bank: directed vectors push expected reads, a negedge monitor pops them.
module tb_gb_register_bank;
    import gb80_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mem;
    } rd_exp_t;

    typedef struct {
        logic        wrEn;
        logic [2:0]  wrAddr;
        logic [7:0]  wrData;
        logic        rdEn;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [1:0]  pairSel;
        logic [1:0]  pairOp;
        logic [15:0] pairData;
        logic [3:0]  flagMask;
        logic [3:0]  flags;
    } stim_t;

    logic    clk;
    logic    rst_n;
    int      checks   = 0;
    int      failures = 0;
    rd_exp_t expQ[$];
    stim_t   s;

    gb_register_bank_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) bus ();

    gb_register_bank #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t t;
        t.wrEn = 1'b0; t.wrAddr = '0; t.wrData = '0;
        t.rdEn = 1'b0; t.ra = '0; t.rb = '0;
        t.pairSel = '0; t.pairOp = OP_NONE; t.pairData = '0;
        t.flagMask = '0; t.flags = '0;
        return t;
    endfunction

    task automatic drive(input stim_t t);
        bus.i_wr_en     = t.wrEn;
        bus.i_wr_addr   = t.wrAddr;
        bus.i_wr_data   = t.wrData;
        bus.i_rd_en     = t.rdEn;
        bus.i_rd_addr_a = t.ra;
        bus.i_rd_addr_b = t.rb;
        bus.i_pair_sel  = t.pairSel;
        bus.i_pair_op   = t.pairOp;
        bus.i_pair_data = t.pairData;
        bus.i_flag_mask = t.flagMask;
        bus.i_flags     = t.flags;
    endtask

    task automatic applyStimulus(input stim_t t);
        drive(t);
        @(posedge clk);
        #1;
        drive(idleStim());
    endtask

    task automatic expectRead(input logic [7:0] a, input logic [7:0] b, input logic mem);
        rd_exp_t e;
        e.a = a; e.b = b; e.mem = mem;
        expQ.push_back(e);
    endtask

    task automatic checkPair(input string name, input logic [1:0] sel, input logic [15:0] expected);
        bus.i_pair_sel = sel;
        #1;
        checkOutput(name, bus.o_pair_data, expected);
        bus.i_pair_sel = 2'd0;
    endtask

    // Every valid read result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.o_rd_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_valid: got rd_valid=1 expected no read outstanding");
            end else begin
                rd_exp_t e;
                e = expQ.pop_front();
                checkOutput("rd_data_a", 16'(bus.o_rd_data_a), 16'(e.a));
                checkOutput("rd_data_b", 16'(bus.o_rd_data_b), 16'(e.b));
                checkOutput("mem_sel",   16'(bus.o_mem_sel),   16'(e.mem));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(idleStim());
        #2;
        checkOutput("reset_valid",   16'(bus.o_rd_valid),  16'h0);
        checkOutput("reset_rd_a",    16'(bus.o_rd_data_a), 16'h0);
        checkOutput("reset_rd_b",    16'(bus.o_rd_data_b), 16'h0);
        checkOutput("reset_mem_sel", 16'(bus.o_mem_sel),   16'h0);
        checkOutput("reset_hl",      bus.o_hl,             16'h0000);
        checkOutput("reset_flags",   16'(bus.o_flags),     16'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            s = idleStim(); s.rdEn = 1'b1; s.ra = 3'(i); s.rb = 3'(7 - i);
            expectRead(8'h00, 8'h00, (i == 6) || (i == 1));
            applyStimulus(s);
        end

        s = idleStim(); s.wrEn = 1'b1; s.wrAddr = REG_B; s.wrData = 8'h12; applyStimulus(s);
        s = idleStim(); s.wrEn = 1'b1; s.wrAddr = REG_C; s.wrData = 8'h34; applyStimulus(s);
        s = idleStim(); s.rdEn = 1'b1; s.ra = REG_B; s.rb = REG_C;
        expectRead(8'h12, 8'h34, 1'b0);
        applyStimulus(s);
        checkPair("pair_bc", PAIR_BC, 16'h1234);

        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_LOAD; s.pairData = 16'h00FF; applyStimulus(s);
        checkOutput("hl_load_00ff", bus.o_hl, 16'h00FF);
        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_INC; applyStimulus(s);
        checkOutput("hl_inc_carry", bus.o_hl, 16'h0100);
        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_LOAD; s.pairData = 16'h0000; applyStimulus(s);
        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_DEC; applyStimulus(s);
        checkOutput("hl_dec_wrap", bus.o_hl, 16'hFFFF);
        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_INC; applyStimulus(s);
        checkOutput("hl_inc_wrap", bus.o_hl, 16'h0000);

        s = idleStim(); s.wrEn = 1'b1; s.wrAddr = REG_D; s.wrData = 8'h55;
        s.rdEn = 1'b1; s.ra = REG_D; s.rb = REG_E;
        expectRead(8'h55, 8'h00, 1'b0);
        applyStimulus(s);

        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_INC;
        s.rdEn = 1'b1; s.ra = REG_H; s.rb = REG_L;
        expectRead(8'h00, 8'h01, 1'b0);
        applyStimulus(s);
        checkOutput("hl_after_bypass", bus.o_hl, 16'h0001);

        s = idleStim(); s.pairSel = PAIR_DE; s.pairOp = OP_LOAD; s.pairData = 16'hABCD;
        s.wrEn = 1'b1; s.wrAddr = REG_B; s.wrData = 8'h77;
        s.rdEn = 1'b1; s.ra = REG_B; s.rb = REG_D;
        expectRead(8'h77, 8'hAB, 1'b0);
        applyStimulus(s);

        s = idleStim(); s.pairSel = PAIR_BC; s.pairOp = OP_LOAD; s.pairData = 16'h2233;
        s.wrEn = 1'b1; s.wrAddr = REG_B; s.wrData = 8'h99;
        s.rdEn = 1'b1; s.ra = REG_B; s.rb = REG_C;
        expectRead(8'h22, 8'h33, 1'b0);
        applyStimulus(s);
        checkPair("pair_over_byte", PAIR_BC, 16'h2233);

        s = idleStim(); s.pairSel = PAIR_AF; s.pairOp = OP_LOAD; s.pairData = 16'h01FF; applyStimulus(s);
        checkPair("af_load_mask", PAIR_AF, 16'h01F0);
        checkOutput("flags_after_load", 16'(bus.o_flags), 16'hF);

        s = idleStim(); s.flagMask = 4'b1001; s.flags = 4'b0000; applyStimulus(s);
        checkOutput("flags_masked", 16'(bus.o_flags), 16'h6);
        checkPair("af_after_flags", PAIR_AF, 16'h0160);

        s = idleStim(); s.pairSel = PAIR_AF; s.pairOp = OP_INC; s.flagMask = 4'b0001; s.flags = 4'b0001;
        s.rdEn = 1'b1; s.ra = REG_A; s.rb = REG_MEM;
        expectRead(8'h02, 8'h00, 1'b1);
        applyStimulus(s);
        checkOutput("flags_over_pairop", 16'(bus.o_flags), 16'h7);
        checkPair("af_inc", PAIR_AF, 16'h0270);

        s = idleStim(); s.pairSel = PAIR_AF; s.pairOp = OP_DEC; applyStimulus(s);
        checkPair("af_dec", PAIR_AF, 16'h0170);
        checkOutput("flags_kept_by_pairop", 16'(bus.o_flags), 16'h7);

        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_INC;
        s.rdEn = 1'b1; s.ra = REG_H; s.rb = REG_L;
        expectRead(8'h00, 8'h02, 1'b0);
        applyStimulus(s);
        s = idleStim(); s.pairSel = PAIR_HL; s.pairOp = OP_INC; s.rdEn = 1'b1; s.ra = REG_L;
        drive(s);
        #6;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_hl",    bus.o_hl,              16'h0000);
        checkOutput("midreset_valid", 16'(bus.o_rd_valid),   16'h0);
        checkOutput("midreset_rd_b",  16'(bus.o_rd_data_b),  16'h0);
        checkOutput("midreset_pair",  bus.o_pair_data,       16'h0000);
        checkOutput("midreset_flags", 16'(bus.o_flags),      16'h0);
        drive(idleStim());
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s = idleStim(); s.rdEn = 1'b1; s.ra = REG_B; s.rb = REG_A;
        expectRead(8'h00, 8'h00, 1'b0);
        applyStimulus(s);
        checkPair("post_reset_af", PAIR_AF, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL read_drain: got %0d reads outstanding expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
